// File: rtl/sha256_pad.sv
// SHA-256 message padder and round sequencer feeding the message-schedule stage.
// Optional length-overflow detection is built when SHA256_PAD_LEN_CHECK_EN is defined.
module sha256_pad #(
  parameter int LEN_W = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  input  logic [1:0]  in_bytes,
  output logic        out_wr_en,
  output logic [31:0] out_data,
  output logic [5:0]  out_t,
  output logic        out_first,
  output logic        out_last,
  output logic        blk_done,
  output logic        err
);
  typedef enum logic [2:0] {DATA, MARK, ZERO, LEN_HI, LEN_LO, EXPAND} state_t;
  typedef enum logic [1:0] {P_DATA, P_MARK, P_ZERO, P_NEW} pend_t;

  state_t           state, pad_nxt;
  pend_t            pend;
  logic [5:0]       t;
  logic [LEN_W-1:0] bitcnt, add;
  logic             first_q, last_q;
  logic [2:0]       nb;
  logic             acc, fits;
  logic [63:0]      len64;

  always_comb begin
    nb    = (in_last && in_bytes != 2'd0) ? {1'b0, in_bytes} : 3'd4;
    acc   = (state == DATA) && in_valid;
    // length words must still fit at t=14/15 behind the marker
    fits  = (nb == 3'd4) ? (t <= 6'd12) : (t <= 6'd13);
    add   = LEN_W'(nb) << 3;
    len64 = 64'(bitcnt);
    if (t == 6'd13)      pad_nxt = LEN_HI;
    else if (t == 6'd15) pad_nxt = EXPAND;
    else                 pad_nxt = ZERO;
  end

  always_comb begin
    in_ready  = (state == DATA);
    out_wr_en = 1'b0;
    out_data  = '0;
    case (state)
      DATA: begin
        out_wr_en = in_valid;
        case (nb)
          3'd1:    out_data = {in_data[31:24], 24'h800000};
          3'd2:    out_data = {in_data[31:16], 16'h8000};
          3'd3:    out_data = {in_data[31:8], 8'h80};
          default: out_data = in_data;
        endcase
      end
      MARK:   begin out_wr_en = 1'b1; out_data = 32'h8000_0000; end
      ZERO:   out_wr_en = 1'b1;
      LEN_HI: begin out_wr_en = 1'b1; out_data = len64[63:32]; end
      LEN_LO: begin out_wr_en = 1'b1; out_data = len64[31:0]; end
      default: ;
    endcase
  end

  assign out_t     = t;
  assign out_first = first_q;
  assign out_last  = last_q | (acc && in_last && fits);
  assign blk_done  = (state == EXPAND) && (t == 6'd63);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= DATA;
      pend    <= P_NEW;
      t       <= '0;
      bitcnt  <= '0;
      first_q <= 1'b1;
      last_q  <= 1'b0;
    end else begin
      case (state)
        DATA: if (in_valid) begin
          t      <= t + 6'd1;
          bitcnt <= bitcnt + add;
          if (in_last) begin
            last_q <= fits;
            if (nb == 3'd4) begin
              if (t == 6'd15) begin state <= EXPAND; pend <= P_MARK; end
              else state <= MARK;
            end else begin
              state <= pad_nxt;
              if (t == 6'd15) pend <= P_ZERO;
            end
          end else if (t == 6'd15) begin
            state <= EXPAND;
            pend  <= P_DATA;
          end
        end
        MARK, ZERO: begin
          t     <= t + 6'd1;
          state <= pad_nxt;
          if (t == 6'd15) pend <= P_ZERO;
        end
        LEN_HI: begin t <= t + 6'd1; state <= LEN_LO; end
        LEN_LO: begin t <= t + 6'd1; state <= EXPAND; pend <= P_NEW; end
        default: begin
          t <= t + 6'd1;
          if (t == 6'd63) begin
            first_q <= (pend == P_NEW);
            case (pend)
              P_DATA:  state <= DATA;
              P_MARK:  begin state <= MARK; last_q <= 1'b1; end
              P_ZERO:  begin state <= ZERO; last_q <= 1'b1; end
              default: begin state <= DATA; bitcnt <= '0; last_q <= 1'b0; end
            endcase
          end
        end
      endcase
    end
  end

`ifdef SHA256_PAD_LEN_CHECK_EN
  logic [LEN_W:0] sum_ext;
  assign sum_ext = {1'b0, bitcnt} + {1'b0, add};
  always_ff @(posedge clk) begin
    if (reset)                     err <= 1'b0;
    else if (acc && sum_ext[LEN_W]) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sha256_pad.sv
// Scoreboard bench for sha256_pad: a byte-level padding model queues expected words.
module tb_sha256_pad;
  logic        clk = 1'b0;
  logic        reset, in_valid, in_last, in_ready, out_wr_en;
  logic        out_first, out_last, blk_done, err;
  logic [31:0] in_data, out_data;
  logic [1:0]  in_bytes;
  logic [5:0]  out_t;

  sha256_pad dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .in_bytes(in_bytes),
    .out_wr_en(out_wr_en), .out_data(out_data), .out_t(out_t),
    .out_first(out_first), .out_last(out_last), .blk_done(blk_done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [5:0]  t;
    logic        first;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0, n_pass = 0;
  int   blocks_exp = 0, blocks_seen = 0;
  int   cyc = 0, done_cyc = 0, t0_cyc = 0;
  bit   mon_en = 1'b1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (out_wr_en) begin
        if (out_t == 6'd0 && in_valid && in_ready) t0_cyc = cyc;
        if (exp_q.size() == 0) chk("unexpected_word", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("data", out_data, e.data);
          chk("t", out_t, e.t);
          chk("first", out_first, e.first);
          chk("last", out_last, e.last);
        end
      end
      if (blk_done) begin
        blocks_seen++;
        done_cyc = cyc;
        chk("done_t", out_t, 63);
      end
      if (out_t >= 6'd16) chk("rdy_expand", in_ready, 0);
    end
  end

  task automatic drive_word(input logic [31:0] d, input logic l, input logic [1:0] b);
    int g = 0;
    in_valid = 1'b1; in_data = d; in_last = l; in_bytes = b;
    while (!in_ready && g < 200) begin @(posedge clk); #1; g++; end
    if (g >= 200) chk("rdy_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // lb: valid bytes in final word, 1..4
  task automatic send_msg(input int n, input int lb, input int gapmax, input bit abc);
    logic [31:0] w[$];
    logic [7:0]  bq[$];
    logic [31:0] tmp;
    longint      L;
    int          nblk;
    for (int i = 0; i < n; i++) w.push_back(abc ? 32'h6162_6300 : $urandom);
    for (int i = 0; i < n; i++) begin
      int nbv;
      nbv = (i == n - 1) ? lb : 4;
      tmp = w[i];
      for (int k = 0; k < nbv; k++) bq.push_back(tmp[31 - 8 * k -: 8]);
    end
    L = bq.size();
    bq.push_back(8'h80);
    while (bq.size() % 64 != 56) bq.push_back(8'h00);
    for (int k = 7; k >= 0; k--) bq.push_back(8'((L * 8) >> (8 * k)));
    nblk = bq.size() / 64;
    for (int j = 0; j < bq.size() / 4; j++) begin
      exp_t e;
      int   blk;
      blk     = j / 16;
      e.data  = {bq[4 * j], bq[4 * j + 1], bq[4 * j + 2], bq[4 * j + 3]};
      e.t     = 6'(j % 16);
      e.first = (blk == 0);
      e.last  = (blk == nblk - 1) && (j >= n - 1 || n - 1 < blk * 16);
      exp_q.push_back(e);
    end
    blocks_exp += nblk;
    for (int i = 0; i < n; i++) begin
      drive_word(w[i], i == n - 1, 2'(lb));
      if (i != n - 1 && gapmax > 0)
        repeat ($urandom_range(0, gapmax)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_blocks();
    int g = 0;
    while (blocks_seen < blocks_exp && g < 3000) begin @(posedge clk); #1; g++; end
    chk("blk_count", blocks_seen, blocks_exp);
    chk("q_empty", exp_q.size(), 0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_t"}, out_t, 0);
    chk({tag, "_rdy"}, in_ready, 1);
    chk({tag, "_first"}, out_first, 1);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_done"}, blk_done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_wr"}, out_wr_en, 0);
  endtask

  initial begin
    int g;
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_bytes = 2'd0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("rst0");
    reset = 1'b0;

    send_msg(1, 3, 0, 1'b1);  wait_blocks();   // "abc"
    send_msg(14, 4, 0, 1'b0); wait_blocks();   // marker at t14, extra block
    send_msg(16, 4, 0, 1'b0); wait_blocks();   // marker opens extra block
    send_msg(13, 4, 0, 1'b0); wait_blocks();   // marker at t13, fits
    send_msg(15, 2, 0, 1'b0); wait_blocks();   // partial last at t14
    send_msg(16, 1, 0, 1'b0); wait_blocks();   // partial last at t15
    send_msg(20, 3, 3, 1'b0); wait_blocks();   // random input gaps

    // mid-block reset discards the partial block
    mon_en = 1'b0;
    for (int i = 0; i < 16; i++) drive_word($urandom, 1'b0, 2'd0);
    g = 0;
    while (out_t != 6'd20 && g < 200) begin @(posedge clk); #1; g++; end
    chk("reach_t20", out_t, 20);
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_state("rst1");
    reset = 1'b0;
    mon_en = 1'b1;
    send_msg(1, 3, 0, 1'b1); wait_blocks();

    // back-to-back: second message accepted the cycle after blk_done
    send_msg(1, 3, 0, 1'b1);
    send_msg(1, 3, 0, 1'b1);
    chk("b2b_gap", 64'(t0_cyc - done_cyc), 1);
    wait_blocks();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
